aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10: number of AES rounds; the round-key SRAM holds NR+1 keys.
REQ-002 Parameter AW, default 4: round-key address width; the block SHALL satisfy 2**AW >= NR+1.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; reset=0 SHALL force the reset state immediately.
REQ-005 key_load  in  1  single-cycle pulse that starts a key expansion.
REQ-006 kexp_en  out  1  enable to the round-key generator, one-cycle pulse.
REQ-007 kexp_we  in  1  write strobe from the round-key generator, one per stored key.
REQ-008 key_ready  out  1  all NR+1 round keys are resident.
REQ-009 blk_valid  in  1  requester offers a block.
REQ-010 blk_ready  out  1  block accepted when blk_valid && blk_ready.
REQ-011 ks_addr  out  AW  round-key SRAM read address.
REQ-012 ks_re  out  1  round-key SRAM read enable; read data is valid one cycle after ks_re.
REQ-013 round_en  out  1  round datapath enable; the key for round_idx is on the SRAM output.
REQ-014 round_idx  out  AW  index of the current round, 0..NR.
REQ-015 first_round / last_round  out  1 each  round_en qualifiers for idx 0 (AddRoundKey only) and idx NR (no MixColumns).
REQ-016 done_valid  out  1  block result available; held until done_ready.
REQ-017 done_ready  in  1  consumer takes the result.
REQ-018 busy  out  1  state is not IDLE and not READY.

Function
REQ-019 States: IDLE (no key), KEXP, READY, RUN, DONE.
REQ-020 IDLE, key_load=1 -> KEXP; kexp_en SHALL pulse in the cycle after key_load; the kexp_we counter SHALL clear.
REQ-021 KEXP: each kexp_we SHALL increment the counter; at count NR+1 -> READY, with key_ready=1 from the next cycle.
REQ-022 kexp_we outside KEXP SHALL be ignored; key_load in KEXP SHALL be ignored.
REQ-023 READY: blk_ready=1; key_load=1 SHALL take priority over blk_valid and go to KEXP with key_ready=0 and blk_ready=0.
REQ-024 Accept in cycle T -> RUN; ks_re=1 with ks_addr=0..NR in cycles T+1..T+NR+1, one address per cycle, ascending.
REQ-025 round_en=1 in cycles T+2..T+NR+2; round_idx equals ks_addr delayed by one cycle.
REQ-026 first_round=1 only with round_idx=0; last_round=1 only with round_idx=NR; both SHALL be 0 whenever round_en=0.
REQ-027 Cycle after the last round_en -> DONE; done_valid=1 from T+NR+3.
REQ-028 DONE: done_valid SHALL stay high until done_ready=1; that cycle -> READY.
REQ-029 Block-to-block accept latency SHALL be NR+4 cycles when done_ready is tied high.
REQ-030 In RUN and DONE, blk_ready=0 and key_load SHALL be ignored; the active block always completes with a consistent key.
REQ-031 ks_addr SHALL never exceed NR; counters SHALL not wrap inside RUN.
REQ-032 When not driven, ks_re, round_en, kexp_en and done_valid SHALL be 0; ks_addr and round_idx SHALL be 0.

Reset
REQ-033 Reset SHALL force: state IDLE, all counters 0, all outputs 0 (key_ready=0, blk_ready=0).
REQ-034 Reset mid-RUN or mid-KEXP SHALL discard the operation; a new key_load is required before any block is accepted.

Verification
REQ-035 key_load, then 11 kexp_we pulses with gaps -> key_ready=1 the cycle after the 11th pulse; blk_ready=1.
REQ-036 blk_valid in READY at T -> ks_addr 0..10 over T+1..T+11; round_en over T+2..T+12; first_round at T+2; last_round at T+12; done_valid at T+13.
REQ-037 done_ready held low for 5 cycles -> done_valid stays 1 and blk_ready=0 throughout; done_ready=1 -> READY on the next cycle.
REQ-038 key_load and blk_valid asserted together in READY -> KEXP, block not accepted, ks_re stays 0.
REQ-039 key_load pulsed during RUN -> ignored, full 11-round sequence completes, key_ready stays 1.
REQ-040 reset asserted at round_idx=5 -> all outputs 0 immediately; blk_valid afterwards not accepted until a full key expansion completes.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: tracks round-key expansion, streams the round keys out of
// the key SRAM one address per cycle, and qualifies the round datapath for each
// accepted block through a valid/ready front end and a held result handshake.
module aes_round_ctrl #(
  parameter int unsigned NR = 10,  // number of rounds; NR+1 round keys
  parameter int unsigned AW = 4    // key address width; needs 2**AW >= NR+1
) (
  input  logic          clk,
  input  logic          reset,        // asynchronous, active-low
  input  logic          key_load,
  output logic          kexp_en,
  input  logic          kexp_we,
  output logic          key_ready,
  input  logic          blk_valid,
  output logic          blk_ready,
  output logic [AW-1:0] ks_addr,
  output logic          ks_re,
  output logic          round_en,
  output logic [AW-1:0] round_idx,
  output logic          first_round,
  output logic          last_round,
  output logic          done_valid,
  input  logic          done_ready,
  output logic          busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEXP  = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW-1:0] LP_LAST_IDX = AW'(NR);
  // One extra bit so the key counter can hold NR+1 even when 2**AW == NR+1.
  localparam logic [AW:0]   LP_LAST_KEY = (AW+1)'(NR);

  logic [2:0]    r_state;
  logic [AW:0]   r_kcnt;
  logic          r_kexp_en;
  logic          r_ks_re;
  logic [AW-1:0] r_ks_addr;
  logic          r_round_en;
  logic [AW-1:0] r_round_idx;

  logic w_start_kexp;
  logic w_accept;
  logic w_last_round;

  assign w_start_kexp = key_load && ((r_state == S_IDLE) || (r_state == S_READY));
  // key_load wins over blk_valid in READY, so a block is never started on a key
  // that is about to be replaced.
  assign w_accept     = (r_state == S_READY) && blk_valid && !key_load;
  assign w_last_round = r_round_en && (r_round_idx == LP_LAST_IDX);

  // Control state machine
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (key_load) r_state <= S_KEXP;
        S_KEXP:  if (kexp_we && (r_kcnt == LP_LAST_KEY)) r_state <= S_READY;
        S_READY: begin
          if (key_load)       r_state <= S_KEXP;
          else if (blk_valid) r_state <= S_RUN;
        end
        S_RUN:   if (w_last_round) r_state <= S_DONE;
        S_DONE:  if (done_ready) r_state <= S_READY;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Key-expansion start pulse and stored-key counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kexp_en <= 1'b0;
      r_kcnt    <= '0;
    end else begin
      r_kexp_en <= w_start_kexp;
      if (w_start_kexp) begin
        r_kcnt <= '0;
      end else if ((r_state == S_KEXP) && kexp_we) begin
        r_kcnt <= r_kcnt + 1'b1;
      end
    end
  end

  // Round-key read address sequencer: 0..NR, one per cycle, then parks at 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ks_re   <= 1'b0;
      r_ks_addr <= '0;
    end else if (w_accept) begin
      r_ks_re   <= 1'b1;
      r_ks_addr <= '0;
    end else if (r_ks_re) begin
      if (r_ks_addr == LP_LAST_IDX) begin
        r_ks_re   <= 1'b0;
        r_ks_addr <= '0;
      end else begin
        r_ks_addr <= r_ks_addr + 1'b1;
      end
    end
  end

  // Round enable/index follow the SRAM read by its one-cycle latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_round_en  <= 1'b0;
      r_round_idx <= '0;
    end else begin
      r_round_en  <= r_ks_re;
      r_round_idx <= r_ks_re ? r_ks_addr : '0;
    end
  end

  assign kexp_en     = r_kexp_en;
  assign ks_re       = r_ks_re;
  assign ks_addr     = r_ks_addr;
  assign round_en    = r_round_en;
  assign round_idx   = r_round_idx;
  assign first_round = r_round_en && (r_round_idx == '0);
  assign last_round  = w_last_round;
  assign blk_ready   = (r_state == S_READY);
  assign done_valid  = (r_state == S_DONE);
  assign key_ready   = (r_state == S_READY) || (r_state == S_RUN) || (r_state == S_DONE);
  assign busy        = (r_state == S_KEXP) || (r_state == S_RUN) || (r_state == S_DONE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl (NR=10, AW=4): stimulus pushes expected
// key reads, rounds and results; a negedge monitor pops and compares them.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_load, kexp_we, blk_valid, done_ready;
  logic          kexp_en, key_ready, blk_ready, ks_re, round_en;
  logic          first_round, last_round, done_valid, busy;
  logic [AW-1:0] ks_addr, round_idx;

  aes_round_ctrl #(.NR(NR), .AW(AW)) dut (
    .clk(clk), .reset(reset), .key_load(key_load), .kexp_en(kexp_en),
    .kexp_we(kexp_we), .key_ready(key_ready), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .ks_addr(ks_addr), .ks_re(ks_re),
    .round_en(round_en), .round_idx(round_idx), .first_round(first_round),
    .last_round(last_round), .done_valid(done_valid), .done_ready(done_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t q_ks[$];
  exp_t q_rd[$];
  exp_t q_done[$];

  // Accept in cycle t: reads at t+1..t+NR+1, rounds at t+2..t+NR+2, result at t+NR+3
  task automatic push_block(input int t);
    for (int i = 0; i <= NR; i++) begin
      q_ks.push_back('{t + 1 + i, i});
      q_rd.push_back('{t + 2 + i, i});
    end
    q_done.push_back('{t + NR + 3, 0});
  endtask

  // Monitor
  logic prev_dv = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (ks_re) begin
      if (q_ks.size() == 0) chk("ks_re_unexpected", 1, 0);
      else begin
        e = q_ks.pop_front();
        chk("ks_cycle", cyc, e.cyc);
        chk("ks_addr", int'(ks_addr), e.val);
      end
    end else begin
      chk("ks_addr_idle", int'(ks_addr), 0);
    end
    if (round_en) begin
      if (q_rd.size() == 0) chk("round_en_unexpected", 1, 0);
      else begin
        e = q_rd.pop_front();
        chk("round_cycle", cyc, e.cyc);
        chk("round_idx", int'(round_idx), e.val);
        chk("first_round", int'(first_round), int'(e.val == 0));
        chk("last_round", int'(last_round), int'(e.val == NR));
      end
    end else begin
      chk("round_idx_idle", int'(round_idx), 0);
      chk("first_idle", int'(first_round), 0);
      chk("last_idle", int'(last_round), 0);
    end
    if (done_valid && !prev_dv) begin
      if (q_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = q_done.pop_front();
        chk("done_cycle", cyc, e.cyc);
      end
    end
    prev_dv <= done_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_kexp_en"}, int'(kexp_en), 0);
    chk({tag, "_key_ready"}, int'(key_ready), 0);
    chk({tag, "_blk_ready"}, int'(blk_ready), 0);
    chk({tag, "_ks_re"}, int'(ks_re), 0);
    chk({tag, "_ks_addr"}, int'(ks_addr), 0);
    chk({tag, "_round_en"}, int'(round_en), 0);
    chk({tag, "_round_idx"}, int'(round_idx), 0);
    chk({tag, "_first"}, int'(first_round), 0);
    chk({tag, "_last"}, int'(last_round), 0);
    chk({tag, "_done_valid"}, int'(done_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // key_load (optionally with blk_valid), then NR+1 kexp_we pulses with gaps;
  // a stray key_load mid-expansion must not restart it.
  task automatic key_expand(input logic with_blk);
    key_load  = 1'b1;
    blk_valid = with_blk;
    tick();
    key_load  = 1'b0;
    blk_valid = 1'b0;
    chk("kexp_en_pulse", int'(kexp_en), 1);
    chk("kexp_key_ready", int'(key_ready), 0);
    chk("kexp_blk_ready", int'(blk_ready), 0);
    chk("kexp_busy", int'(busy), 1);
    chk("kexp_no_read", int'(ks_re), 0);
    tick();
    chk("kexp_en_single", int'(kexp_en), 0);
    for (int i = 0; i <= NR; i++) begin
      kexp_we  = 1'b1;
      key_load = (i == 3);
      tick();
      kexp_we  = 1'b0;
      key_load = 1'b0;
      if (i < NR) begin
        chk("kexp_not_ready", int'(key_ready), 0);
        chk("kexp_reload_ignored", int'(kexp_en), 0);
        ticks(1 + (i % 2));
      end else begin
        chk("key_ready_after_last", int'(key_ready), 1);
        chk("blk_ready_after_kexp", int'(blk_ready), 1);
        chk("busy_ready", int'(busy), 0);
      end
    end
  endtask

  task automatic send_block(output int t);
    blk_valid = 1'b1;
    chk("blk_ready_offer", int'(blk_ready), 1);
    t = cyc;
    push_block(t);
    tick();
    blk_valid = 1'b0;
    chk("run_busy", int'(busy), 1);
    chk("run_blk_ready", int'(blk_ready), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_valid && n < 40) begin
      tick();
      n++;
    end
    if (!done_valid) chk("done_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin : stim
    int t;
    int acc[2];
    int na;

    reset = 1'b0; key_load = 1'b0; kexp_we = 1'b0;
    blk_valid = 1'b0; done_ready = 1'b0;
    ticks(3);
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    check_all_zero("idle");

    // No key: blocks refused, stray kexp_we ignored
    blk_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      kexp_we = (i % 2 == 0);
      tick();
      chk("idle_blk_ready", int'(blk_ready), 0);
      chk("idle_key_ready", int'(key_ready), 0);
    end
    blk_valid = 1'b0;
    kexp_we = 1'b0;

    key_expand(1'b0);

    // One block, result held while done_ready is low
    send_block(t);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      chk("hold_done_valid", int'(done_valid), 1);
      chk("hold_blk_ready", int'(blk_ready), 0);
      tick();
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("after_done_ready", int'(blk_ready), 1);
    chk("after_done_valid", int'(done_valid), 0);

    // Back-to-back blocks with done_ready tied high
    done_ready = 1'b1;
    blk_valid  = 1'b1;
    na = 0;
    for (int i = 0; i < 60 && na < 2; i++) begin
      if (blk_ready) begin
        acc[na] = cyc;
        push_block(cyc);
        na++;
      end
      tick();
    end
    blk_valid = 1'b0;
    chk("b2b_accepts", na, 2);
    if (na == 2) chk("b2b_latency", acc[1] - acc[0], NR + 4);
    wait_done();
    tick();
    done_ready = 1'b0;
    chk("b2b_back_ready", int'(blk_ready), 1);

    // key_load beats blk_valid in READY
    key_expand(1'b1);

    // key_load during RUN is ignored
    send_block(t);
    ticks(3);
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("run_reload_kexp_en", int'(kexp_en), 0);
    chk("run_reload_key_ready", int'(key_ready), 1);
    wait_done();
    chk("done_key_ready", int'(key_ready), 1);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("run_reload_ready", int'(blk_ready), 1);

    // Reset in the middle of round 5
    send_block(t);
    for (int i = 0; i < 20 && cyc < t + 7; i++) tick();
    chk("pre_reset_idx", int'(round_idx), 5);
    #1 reset = 1'b0;
    #1 check_all_zero("async_reset");
    q_ks.delete();
    q_rd.delete();
    q_done.delete();
    ticks(2);
    reset = 1'b1;
    blk_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_blk_ready", int'(blk_ready), 0);
    end
    blk_valid = 1'b0;
    key_expand(1'b0);
    send_block(t);
    wait_done();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    ticks(2);

    chk("ks_queue_empty", q_ks.size(), 0);
    chk("round_queue_empty", q_rd.size(), 0);
    chk("done_queue_empty", q_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
